ex_operand_stage: RTL
=====================

# ex_operand_stage

ID/EX pipeline register plus EX-stage operand forwarding and source selection. Sits directly upstream of the ALU: it latches decoded instruction fields from ID and drives the ALU's Operand1, Operand2 and AluContrl inputs. It also supplies the forwarded rs2 value (store data) and the destination fields that travel on to EX/MEM. Stall and flush from the hazard unit control whether the stage holds, loads, or becomes a bubble.

## Interface
Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register-address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall_e  in  1  hold current contents (EX stalled)
- flush_e  in  1  replace contents with a bubble on next edge
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses
- id_imm  in  XLEN  sign-extended immediate
- id_alu_ctrl  in  4  ALU operation code (shared `ADD … `LUI encodings)
- id_op1_sel  in  1  0 = rs1, 1 = PC
- id_op2_sel  in  1  0 = rs2, 1 = imm
- id_reg_write  in  1  instruction writes rd
- mem_rd, wb_rd  in  RA_W  destination of the instruction in MEM / WB
- mem_reg_write, wb_reg_write  in  1  MEM / WB instruction writes its rd
- mem_result, wb_result  in  XLEN  value produced in MEM / WB
- operand1, operand2  out  XLEN  ALU operands (combinational from stage registers)
- alu_ctrl  out  4  ALU operation code
- ex_store_data  out  XLEN  forwarded rs2 value
- ex_valid, ex_reg_write  out  1  qualified valid and write-enable
- ex_rd  out  RA_W  destination register
- ex_pc, ex_imm  out  XLEN  passed to branch/jump logic

## Operation
- Edge priority: rst > flush_e > stall_e > load.
- Load: every id_* field is captured. ex_reg_write = id_reg_write & id_valid.
- Flush (bubble):
  - valid = 0, reg_write = 0, rd = 0.
  - alu_ctrl = `ADD; stored rs1/rs2 data = 0.
  - pc and imm = 0, op1_sel = 0, op2_sel = 0.
- Stall: all fields hold, except the stored rs1/rs2 data registers, which re-capture their forwarded values (fwd1/fwd2 below).
  - A value forwarded from WB during a multi-cycle stall is therefore not lost when WB retires.
- Forwarding, applied separately to rs1 and rs2 using the registered addresses:
  - The MEM source matches when mem_reg_write = 1, mem_rd = rs, and rs ≠ 0. On a match, the MEM value wins.
  - Otherwise the WB source matches under the same conditions using wb_reg_write / wb_rd. On a match, the WB value is used.
  - Otherwise the stored register data is used.
  - Register x0 is never forwarded; its operand is the stored data, which is 0 when read from the register file.
- operand1 = op1_sel ? pc : fwd1.
- operand2 = op2_sel ? imm : fwd2.
- ex_store_data = fwd2, regardless of op2_sel.
- No arithmetic is performed here; all values are full XLEN width with no truncation.

## Timing
- Reset (asynchronous): every registered field is 0 except alu_ctrl = `ADD.
  - Outputs after reset: ex_valid 0, ex_reg_write 0, ex_rd 0, ex_pc 0, ex_imm 0, operand1 0, operand2 0, ex_store_data 0, alu_ctrl `ADD.
  - The rs1/rs2 forwarding matches are still evaluated combinationally against the MEM/WB inputs; with rs = 0 after reset, no match occurs.
- Latency: id_* sampled at edge N appear at ex_* after edge N.
- operand1, operand2 and ex_store_data are combinational in the same cycle as the mem_* / wb_* inputs; there are no registers on this path.
- flush_e and stall_e asserted together: the flush wins and a bubble is loaded.
- rst asserted mid-stall or mid-flush: contents clear immediately, without waiting for a clock edge.
- A stall of k cycles followed by release: the instruction leaves with forwarded data reflecting the last refresh edge.

## Structure
- Forward-select encodings (FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10) go in the shared Parameters header, alongside the existing ALU control codes. The bubble alu_ctrl value references `ADD from the same header.
- One sub-module, ex_fwd_mux. Inputs: rs address, stored data, and the MEM/WB address/enable/value. Outputs: the forwarded value and its select code. Instantiated twice (rs1, rs2).
- The top level holds the pipeline register, the stall/flush priority logic, and the op1/op2 source muxes.

## Test plan
- Reset, then load: load ADD with rs1_data 5, rs2_data 7, op_sel 0/0, rd 3 → after one edge, operand1 5, operand2 7, alu_ctrl `ADD, ex_rd 3, ex_valid 1, ex_reg_write 1.
- MEM and WB both match: rs1 = 4, mem_rd 4 with value 0x11, wb_rd 4 with value 0x22, both write → operand1 0x11. Drop mem_reg_write → operand1 0x22.
- Forward to x0: rs1 = 0, mem_rd 0, mem_result 0xDEAD, mem_reg_write 1 → operand1 0.
- Stall refresh: stall_e high for 3 cycles; WB forwards 0x99 to rs2 only in cycle 1 → after release, ex_store_data 0x99 and operand2 0x99.
- Flush and stall together: flush_e and stall_e both high → ex_valid 0, ex_reg_write 0, alu_ctrl `ADD, operand1 0.
- Source select and async reset: op1_sel 1, op2_sel 1, pc 0x100, imm 0xFFFFFFFC → operand1 0x100, operand2 0xFFFFFFFC, ex_store_data still the forwarded rs2 value. Then rst asserted between edges → all outputs are at their reset values before the next edge.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// ex_operand_stage shared definitions:
// ALU control codes and forward-select encodings.
package ex_operand_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage bus: ID inputs, hazard controls,
// MEM/WB forwarding sources and EX outputs.
interface ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  import ex_operand_stage_pkg::*;

  logic            stall_e;
  logic            flush_e;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic [XLEN-1:0] id_imm;
  logic [3:0]      id_alu_ctrl;
  logic            id_op1_sel;
  logic            id_op2_sel;
  logic            id_reg_write;
  logic [RA_W-1:0] mem_rd;
  logic [RA_W-1:0] wb_rd;
  logic            mem_reg_write;
  logic            wb_reg_write;
  logic [XLEN-1:0] mem_result;
  logic [XLEN-1:0] wb_result;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] ex_store_data;
  logic            ex_valid;
  logic            ex_reg_write;
  logic [RA_W-1:0] ex_rd;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  fwd_sel_e        fwd1_sel;
  fwd_sel_e        fwd2_sel;

  modport master (
    output stall_e, flush_e, id_valid, id_pc,
    output id_rs1_data, id_rs2_data,
    output id_rs1, id_rs2, id_rd, id_imm,
    output id_alu_ctrl, id_op1_sel, id_op2_sel,
    output id_reg_write,
    output mem_rd, wb_rd, mem_reg_write,
    output wb_reg_write, mem_result, wb_result,
    input  operand1, operand2, alu_ctrl,
    input  ex_store_data, ex_valid, ex_reg_write,
    input  ex_rd, ex_pc, ex_imm,
    input  fwd1_sel, fwd2_sel
  );

  modport slave (
    input  stall_e, flush_e, id_valid, id_pc,
    input  id_rs1_data, id_rs2_data,
    input  id_rs1, id_rs2, id_rd, id_imm,
    input  id_alu_ctrl, id_op1_sel, id_op2_sel,
    input  id_reg_write,
    input  mem_rd, wb_rd, mem_reg_write,
    input  wb_reg_write, mem_result, wb_result,
    output operand1, operand2, alu_ctrl,
    output ex_store_data, ex_valid, ex_reg_write,
    output ex_rd, ex_pc, ex_imm,
    output fwd1_sel, fwd2_sel
  );
endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand forwarding: MEM beats WB beats stored data;
// x0 is never forwarded.
module ex_fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic            mem_we_i,
  input  logic [XLEN-1:0] mem_val_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic            wb_we_i,
  input  logic [XLEN-1:0] wb_val_i,
  output logic [XLEN-1:0] fwd_o,
  output fwd_sel_e        sel_o
);

  logic nz;
  logic mem_hit;
  logic wb_hit;

  assign nz      = |rs_i;
  assign mem_hit = nz & mem_we_i & (mem_rd_i == rs_i);
  assign wb_hit  = nz & wb_we_i & (wb_rd_i == rs_i);

  // Priority select of the freshest producer.
  always_comb begin
    sel_o = FWD_REG;
    fwd_o = data_i;
    if (mem_hit) begin
      sel_o = FWD_MEM;
      fwd_o = mem_val_i;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
      fwd_o = wb_val_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with stall/flush control,
// operand forwarding and ALU source selection.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic          clk,
  input logic          rst,
  ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu;
    logic            op1_sel;
    logic            op2_sel;
  } ex_regs_t;

  ex_regs_t        regs_q;
  ex_regs_t        regs_d;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd1 (
    .rs_i      (regs_q.rs1),
    .data_i    (regs_q.rs1_data),
    .mem_rd_i  (bus.mem_rd),
    .mem_we_i  (bus.mem_reg_write),
    .mem_val_i (bus.mem_result),
    .wb_rd_i   (bus.wb_rd),
    .wb_we_i   (bus.wb_reg_write),
    .wb_val_i  (bus.wb_result),
    .fwd_o     (fwd1),
    .sel_o     (bus.fwd1_sel)
  );

  ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd2 (
    .rs_i      (regs_q.rs2),
    .data_i    (regs_q.rs2_data),
    .mem_rd_i  (bus.mem_rd),
    .mem_we_i  (bus.mem_reg_write),
    .mem_val_i (bus.mem_result),
    .wb_rd_i   (bus.wb_rd),
    .wb_we_i   (bus.wb_reg_write),
    .wb_val_i  (bus.wb_result),
    .fwd_o     (fwd2),
    .sel_o     (bus.fwd2_sel)
  );

  // Next state: flush > stall (refresh operands) > load.
  always_comb begin
    regs_d = regs_q;
    if (bus.flush_e) begin
      regs_d     = '0;
      regs_d.alu = ALU_ADD;
    end else if (bus.stall_e) begin
      regs_d.rs1_data = fwd1;
      regs_d.rs2_data = fwd2;
    end else begin
      regs_d.valid     = bus.id_valid;
      regs_d.reg_write = bus.id_reg_write & bus.id_valid;
      regs_d.rd        = bus.id_rd;
      regs_d.rs1       = bus.id_rs1;
      regs_d.rs2       = bus.id_rs2;
      regs_d.rs1_data  = bus.id_rs1_data;
      regs_d.rs2_data  = bus.id_rs2_data;
      regs_d.pc        = bus.id_pc;
      regs_d.imm       = bus.id_imm;
      regs_d.alu       = bus.id_alu_ctrl;
      regs_d.op1_sel   = bus.id_op1_sel;
      regs_d.op2_sel   = bus.id_op2_sel;
    end
  end

  // Stage register, cleared to a bubble on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '0;
      regs_q.alu <= ALU_ADD;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.operand1      = regs_q.op1_sel ? regs_q.pc : fwd1;
  assign bus.operand2      = regs_q.op2_sel ? regs_q.imm : fwd2;
  assign bus.ex_store_data = fwd2;
  assign bus.alu_ctrl      = regs_q.alu;
  assign bus.ex_valid      = regs_q.valid;
  assign bus.ex_reg_write  = regs_q.reg_write;
  assign bus.ex_rd         = regs_q.rd;
  assign bus.ex_pc         = regs_q.pc;
  assign bus.ex_imm        = regs_q.imm;

endmodule
